// File: rtl/window_stream.sv
// window_stream: streaming sample windowing with a run-time programmable
// coefficient table, two-stage valid/ready pipeline and end-of-frame marker.
// Optional feature macro: WINDOW_ROUND_EN (round half-up instead of
// truncation toward minus infinity before saturation).
module window_stream #(
   parameter  int unsigned N  = 8,
   parameter  int unsigned DW = 8,
   parameter  int unsigned CW = 8,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          restart,
   input  logic          coef_we,
   input  logic [IW-1:0] coef_addr,
   input  logic [CW-1:0] coef_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   output logic [15:0]   frame_cnt
);

   localparam int unsigned PW = DW + CW + 1;
   localparam int unsigned RW = PW + 1;
   localparam logic [CW-1:0] UNITY    = CW'(2 ** (CW - 1));
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
`ifdef WINDOW_ROUND_EN
   localparam int unsigned RND = 2 ** (CW - 2);
`else
   localparam int unsigned RND = 0;
`endif
   localparam logic signed [RW-1:0] SAT_HI = RW'(2 ** (DW - 1) - 1);
   localparam logic signed [RW-1:0] SAT_LO = RW'(-(2 ** (DW - 1)));

   logic [CW-1:0]          coef_q [N];
   logic [IW-1:0]          idx_q;
   logic [IW-1:0]          idx_use;
   logic                   use_last;
   logic                   en;
   logic                   accept;
   logic signed [PW-1:0]   a_ext;
   logic signed [PW-1:0]   c_ext;
   logic signed [PW-1:0]   prod;
   logic                   s1_valid;
   logic                   s1_last;
   logic signed [PW-1:0]   s1_prod;
   logic signed [RW-1:0]   sum;
   logic signed [RW-1:0]   r;
   logic [DW-1:0]          res;

   // Handshake, effective index (restart forces index 0) and S1 product.
   always_comb begin
      en       = !m_valid || m_ready;
      s_ready  = en;
      accept   = s_valid && en;
      idx_use  = restart ? '0 : idx_q;
      use_last = (idx_use == LAST_IDX);
      a_ext    = {{(CW + 1){s_data[DW-1]}}, s_data};
      c_ext    = {{(DW + 1){1'b0}}, coef_q[idx_use]};
      prod     = a_ext * c_ext;
   end

   // Coefficient table; out-of-range addresses match no entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < N; i++) coef_q[i] <= UNITY;
      end else if (coef_we) begin
         for (int unsigned i = 0; i < N; i++)
            if (coef_addr == IW'(i)) coef_q[i] <= coef_data;
      end
   end

   // Frame index and completed-frame counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q     <= '0;
         frame_cnt <= '0;
      end else if (accept) begin
         idx_q <= use_last ? '0 : idx_use + IW'(1);
         if (use_last) frame_cnt <= frame_cnt + 16'd1;
      end else if (restart) begin
         idx_q <= '0;
      end
   end

   // S1: product, last flag and valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_prod  <= '0;
      end else if (en) begin
         s1_valid <= accept;
         s1_last  <= use_last;
         s1_prod  <= prod;
      end
   end

   // Rounding (optional), arithmetic shift and saturation.
   always_comb begin
      sum = RW'(s1_prod) + RW'(RND);
      r   = sum >>> (CW - 1);
      res = DW'(r);
      if (r > SAT_HI)      res = DW'(SAT_HI);
      else if (r < SAT_LO) res = DW'(SAT_LO);
   end

   // S2: output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else if (en) begin
         m_valid <= s1_valid;
         m_data  <= res;
         m_last  <= s1_last;
      end
   end

endmodule

// File: tb/tb_window_stream.sv
// Bench for window_stream: directed vector table, hand sequences for latency,
// backpressure, restart and mid-stream reset, then random traffic against a
// queue-based frame model.
module tb_window_stream;

   localparam int N  = 8;
   localparam int DW = 8;
   localparam int CW = 8;
   localparam int IW = $clog2(N);

   logic          clk;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          restart;
   logic          coef_we;
   logic [IW-1:0] coef_addr;
   logic [CW-1:0] coef_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic [15:0]   frame_cnt;

   window_stream #(.N(N), .DW(DW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .restart(restart), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_data(coef_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int  data;
      bit  last;
   } exp_t;

   typedef struct {
      int coef;
      int x;
      int expv;
   } vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   tbl [N];
   int   m_idx;
   int   m_fc;
   exp_t q [$];

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Windowed value from first principles: floor((x*c [+ half]) / unity), clamped.
   function automatic int model_out(input int x, input int c);
      int v, d, qv;
      v = x * c;
`ifdef WINDOW_ROUND_EN
      v = v + 2 ** (CW - 2);
`endif
      d  = 2 ** (CW - 1);
      qv = v / d;
      if (v < 0 && (v % d) != 0) qv = qv - 1;
      if (qv > 2 ** (DW - 1) - 1) qv = 2 ** (DW - 1) - 1;
      if (qv < -(2 ** (DW - 1))) qv = -(2 ** (DW - 1));
      return qv;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N; i++) tbl[i] = 2 ** (CW - 1);
      m_idx = 0;
      m_fc  = 0;
      q.delete();
   endfunction

   // One clock: compare at negedge, advance the model for the coming edge.
   task automatic step();
      int use_i;
      exp_t e;
      @(negedge clk);
      check("frame_cnt", int'(frame_cnt), m_fc);
      if (m_valid && m_ready) begin
         if (q.size() == 0) begin
            check("spurious_output", 1, 0);
         end else begin
            e = q.pop_front();
            check("m_data", int'($signed(m_data)), e.data);
            check("m_last", int'(m_last), int'(e.last));
         end
      end
      if (s_valid && s_ready) begin
         use_i  = restart ? 0 : m_idx;
         e.data = model_out(int'($signed(s_data)), tbl[use_i]);
         e.last = (use_i == N - 1);
         q.push_back(e);
         if (use_i == N - 1) m_fc = (m_fc + 1) % 65536;
         m_idx = (use_i + 1) % N;
      end else if (restart) begin
         m_idx = 0;
      end
      if (coef_we && int'(coef_addr) < N) tbl[coef_addr] = int'(coef_data);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      s_valid = 1'b0; restart = 1'b0; coef_we = 1'b0; m_ready = 1'b1;
   endtask

   task automatic drain();
      idle_inputs();
      for (int k = 0; k < 12 && q.size() > 0; k++) step();
      check("drain_empty", q.size(), 0);
   endtask

   task automatic write_coef(input int a, input int c);
      coef_we = 1'b1; coef_addr = IW'(a); coef_data = CW'(c);
      step();
      coef_we = 1'b0;
   endtask

   vec_t vecs [12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int held;
      int fc_before;

      vecs[0]  = '{128, 5, 5};
      vecs[1]  = '{128, -3, -3};
      vecs[2]  = '{128, 127, 127};
      vecs[3]  = '{128, -128, -128};
      vecs[4]  = '{255, 127, 127};
      vecs[5]  = '{255, -128, -128};
      vecs[6]  = '{0, 100, 0};
      vecs[7]  = '{255, 0, 0};
`ifdef WINDOW_ROUND_EN
      vecs[8]  = '{64, 7, 4};
      vecs[9]  = '{64, -7, -3};
      vecs[10] = '{200, -50, -78};
      vecs[11] = '{1, -1, 0};
`else
      vecs[8]  = '{64, 7, 3};
      vecs[9]  = '{64, -7, -4};
      vecs[10] = '{200, -50, -79};
      vecs[11] = '{1, -1, -1};
`endif

      // Reset state.
      rst = 1'b0; s_data = '0; coef_addr = '0; coef_data = '0;
      idle_inputs();
      model_reset();
      #12;
      check("rst_m_valid", int'(m_valid), 0);
      check("rst_m_data", int'(m_data), 0);
      check("rst_m_last", int'(m_last), 0);
      check("rst_frame_cnt", int'(frame_cnt), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_s_ready", int'(s_ready), 1);

      // Latency of a single sample with the reset (unity) table.
      s_valid = 1'b1; s_data = 8'(5);
      step();
      s_valid = 1'b0;
      check("lat1_m_valid", int'(m_valid), 0);
      step();
      check("lat2_m_valid", int'(m_valid), 1);
      check("lat2_m_data", int'($signed(m_data)), 5);

      // Rest of the first frame, back to back.
      s_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: s_data = 8'(-3);
            1: s_data = 8'(127);
            2: s_data = 8'(-128);
            default: s_data = 8'($urandom_range(0, 255));
         endcase
         step();
      end
      drain();
      check("frame1_cnt", int'(frame_cnt), 1);

      // Coefficient/sample table; each sample restarts so it uses index 0.
      for (int i = 0; i < 12; i++) begin
         write_coef(0, vecs[i].coef);
         s_valid = 1'b1; restart = 1'b1; s_data = 8'(vecs[i].x);
         step();
         s_valid = 1'b0; restart = 1'b0;
         step();
         check($sformatf("vec%0d", i), int'($signed(m_data)), vecs[i].expv);
         step();
      end
      write_coef(0, 128);
      drain();

      // Backpressure: m_ready low for 5 cycles mid-stream.
      held = 0;
      s_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         m_ready = !(c >= 6 && c < 11);
         s_data  = 8'($urandom_range(0, 255));
         #1;
         if (c >= 6 && c < 11) begin
            check("bp_s_ready", int'(s_ready), 0);
            check("bp_m_valid", int'(m_valid), 1);
            if (c > 6) check("bp_hold", int'(m_data), held);
            held = int'(m_data);
         end
         step();
      end
      drain();

      // Restart coincident with the 4th accept.
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_data = 8'($urandom_range(0, 255));
         step();
      end
      fc_before = m_fc;
      restart = 1'b1; s_data = 8'(11);
      step();
      restart = 1'b0;
      check("restart_fc_hold", int'(frame_cnt), fc_before);
      for (int i = 0; i < 7; i++) begin
         s_data = 8'(20 + i);
         step();
      end
      drain();
      check("restart_fc_after", int'(frame_cnt), (fc_before + 1) % 65536);

      // Mid-stream reset with samples in flight.
      write_coef(2, 50);
      s_valid = 1'b1; s_data = 8'(40);
      step();
      s_data = 8'(41);
      step();
      s_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("mrst_m_valid", int'(m_valid), 0);
      check("mrst_m_data", int'(m_data), 0);
      check("mrst_frame_cnt", int'(frame_cnt), 0);
      model_reset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b1; s_data = 8'(100);
      for (int i = 0; i < 8; i++) step();
      drain();
      check("mrst_frame_cnt_after", int'(frame_cnt), 1);

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         s_valid   = ($urandom_range(0, 3) != 0);
         m_ready   = ($urandom_range(0, 3) != 0);
         restart   = ($urandom_range(0, 19) == 0);
         coef_we   = ($urandom_range(0, 7) == 0);
         coef_addr = IW'($urandom_range(0, N - 1));
         coef_data = CW'($urandom_range(0, 255));
         s_data    = DW'($urandom_range(0, 255));
         step();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
